// File: rtl/des_key_schedule_seq_if.sv
// Key-in / subkey-out handshake bundle for the sequential DES key-schedule engine.
// The engine connects through the slave modport and the key source/consumer through master.
interface des_key_schedule_seq_if;
  logic [63:0] key;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic [4:0]  subkey_round;
  logic        subkey_last;
  logic        subkey_valid;
  logic        subkey_ready;

  modport master (
    output key, decrypt, key_valid, subkey_ready,
    input  key_ready, subkey, subkey_round, subkey_last, subkey_valid
  );

  modport slave (
    input  key, decrypt, key_valid, subkey_ready,
    output key_ready, subkey, subkey_round, subkey_last, subkey_valid
  );
endinterface

// File: rtl/des_key_schedule_seq.sv
// Sequential DES key schedule: accepts one key, then streams ROUNDS subkeys one per beat,
// in encrypt (K1..Kn) or decrypt (Kn..K1) order, honouring consumer backpressure.
module des_key_schedule_seq #(
  parameter int          ROUNDS     = 16,
  parameter logic [15:0] SHIFT_MASK = 16'h7EFC
) (
  input logic               clk,
  input logic               rst,
  des_key_schedule_seq_if.slave bus
);

  if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
    $error("des_key_schedule_seq: ROUNDS must be in 1..16");
  end

  typedef enum logic {IDLE, RUN} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Tables use DES 1-based MSB-first numbering, so DES bit n lives at vector index width-n.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [4:0] shift_amt(input logic [4:0] rnd);
    logic [3:0] idx;
    logic [4:0] amt;
    idx = 4'(rnd - 5'd1);
    amt = 5'd1;
    if (rnd >= 5'd1 && rnd <= 5'd16) amt = SHIFT_MASK[idx] ? 5'd2 : 5'd1;
    return amt;
  endfunction

  function automatic int total_shift();
    int sum;
    sum = 0;
    for (int i = 0; i < ROUNDS; i++) sum += SHIFT_MASK[i] ? 2 : 1;
    return sum;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
    return rotl28(x, 5'd28 - n);
  endfunction

  // Decrypt starts from C/D as they stand after the last round, i.e. the cumulative rotation.
  localparam logic [4:0] LOAD_ROT   = 5'(total_shift() % 28);
  localparam logic [4:0] ROUNDS_VAL = 5'(ROUNDS);

  state_t      state;
  logic [27:0] c_q, d_q;
  logic        dec_q;
  logic        key_ready_q;
  logic        valid_q;
  logic [47:0] subkey_q;
  logic [4:0]  round_q;
  logic        last_q;

  logic        accept;
  logic [55:0] cd_key;
  logic [27:0] c_src, d_src, c_nxt, d_nxt;
  logic [4:0]  rot_amt, round_nxt;
  logic        rot_left, dec_sel, last_nxt;
  logic [47:0] subkey_nxt;

  assign accept = (state == IDLE) && key_ready_q && bus.key_valid;
  assign cd_key = pc1(bus.key);

  // NOTE: every always_comb output gets a default up front so no path leaves a latch behind.
  always_comb begin
    c_src     = c_q;
    d_src     = d_q;
    rot_left  = 1'b1;
    rot_amt   = shift_amt(round_q + 5'd1);
    round_nxt = round_q + 5'd1;
    dec_sel   = dec_q;
    if (accept) begin
      c_src   = cd_key[55:28];
      d_src   = cd_key[27:0];
      dec_sel = bus.decrypt;
      if (bus.decrypt) begin
        rot_amt   = LOAD_ROT;
        round_nxt = ROUNDS_VAL;
      end else begin
        rot_amt   = shift_amt(5'd1);
        round_nxt = 5'd1;
      end
    end else if (dec_q) begin
      // Undo the rotation of the round just emitted to step back one round.
      rot_left  = 1'b0;
      rot_amt   = shift_amt(round_q);
      round_nxt = round_q - 5'd1;
    end
    c_nxt      = rot_left ? rotl28(c_src, rot_amt) : rotr28(c_src, rot_amt);
    d_nxt      = rot_left ? rotl28(d_src, rot_amt) : rotr28(d_src, rot_amt);
    subkey_nxt = pc2({c_nxt, d_nxt});
    last_nxt   = dec_sel ? (round_nxt == 5'd1) : (round_nxt == ROUNDS_VAL);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      c_q         <= '0;
      d_q         <= '0;
      dec_q       <= 1'b0;
      key_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      subkey_q    <= '0;
      round_q     <= '0;
      last_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= RUN;
            key_ready_q <= 1'b0;
            dec_q       <= bus.decrypt;
            c_q         <= c_nxt;
            d_q         <= d_nxt;
            subkey_q    <= subkey_nxt;
            round_q     <= round_nxt;
            last_q      <= last_nxt;
            valid_q     <= 1'b1;
          end else begin
            key_ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (valid_q && bus.subkey_ready) begin
            if (last_q) begin
              state       <= IDLE;
              valid_q     <= 1'b0;
              key_ready_q <= 1'b1;
            end else begin
              c_q      <= c_nxt;
              d_q      <= d_nxt;
              subkey_q <= subkey_nxt;
              round_q  <= round_nxt;
              last_q   <= last_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.key_ready    = key_ready_q;
  assign bus.subkey_valid = valid_q;
  assign bus.subkey       = subkey_q;
  assign bus.subkey_round = round_q;
  assign bus.subkey_last  = last_q;

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Scoreboard bench for des_key_schedule_seq: a 16-round and a 4-round instance, checked against
// the published DES subkeys of key 133457799BBCDFF1.
module tb_des_key_schedule_seq;

  localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY = 64'h0101010101010101;

  localparam logic [47:0] KTAB [16] = '{
    48'b000110_110000_001011_101111_111111_000111_000001_110010,
    48'b011110_011010_111011_011001_110110_111100_100111_100101,
    48'b010101_011111_110010_001010_010000_101100_111110_011001,
    48'b011100_101010_110111_010110_110110_110011_010100_011101,
    48'b011111_001110_110000_000111_111010_110101_001110_101000,
    48'b011000_111010_010100_111110_010100_000111_101100_101111,
    48'b111011_001000_010010_110111_111101_100001_100010_111100,
    48'b111101_111000_101000_111010_110000_010011_101111_111011,
    48'b111000_001101_101111_101011_111011_011110_011110_000001,
    48'b101100_011111_001101_000111_101110_100100_011001_001111,
    48'b001000_010101_111111_010011_110111_101101_001110_000110,
    48'b011101_010111_000111_110101_100101_000110_011111_101001,
    48'b100101_111100_010111_010001_111110_101011_101001_000001,
    48'b010111_110100_001110_110111_111100_101110_011100_111010,
    48'b101111_111001_000110_001101_001111_010011_111100_001010,
    48'b110010_110011_110110_001011_000011_100001_011111_110101
  };

  typedef struct packed {
    logic [47:0] subkey;
    logic [4:0]  round;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [63:0] drv_key = '0;
  logic        drv_decrypt = 1'b0;
  logic        drv_key_valid = 1'b0;
  logic        drv_ready = 1'b0;

  beat_t sb[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  des_key_schedule_seq_if bus16 ();
  des_key_schedule_seq_if bus4 ();

  assign bus16.key          = drv_key;
  assign bus16.decrypt      = drv_decrypt;
  assign bus16.key_valid    = drv_key_valid & ~sel;
  assign bus16.subkey_ready = drv_ready & ~sel;
  assign bus4.key           = drv_key;
  assign bus4.decrypt       = drv_decrypt;
  assign bus4.key_valid     = drv_key_valid & sel;
  assign bus4.subkey_ready  = drv_ready & sel;

  des_key_schedule_seq #(.ROUNDS(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  des_key_schedule_seq #(.ROUNDS(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

  logic        o_valid, o_last, o_key_ready;
  logic [47:0] o_sub;
  logic [4:0]  o_round;
  assign o_valid     = sel ? bus4.subkey_valid : bus16.subkey_valid;
  assign o_last      = sel ? bus4.subkey_last  : bus16.subkey_last;
  assign o_key_ready = sel ? bus4.key_ready    : bus16.key_ready;
  assign o_sub       = sel ? bus4.subkey       : bus16.subkey;
  assign o_round     = sel ? bus4.subkey_round : bus16.subkey_round;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int n, input bit dec);
    beat_t b;
    int    r;
    for (int i = 0; i < n; i++) begin
      r        = dec ? n - i : i + 1;
      b.subkey = KTAB[r-1];
      b.round  = 5'(r);
      b.last   = (i == n - 1);
      sb.push_back(b);
    end
  endtask

  task automatic send_key(input logic [63:0] k, input bit dec, input int n);
    int w;
    w = 0;
    while (!o_key_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("key_ready_idle", o_key_ready, 1);
    drv_key       = k;
    drv_decrypt   = dec;
    drv_key_valid = 1'b1;
    push_expected(n, dec);
    @(posedge clk); #1;
    drv_key_valid = 1'b0;
    drv_key       = ~k;
    drv_decrypt   = ~dec;
    check("key_ready_busy", o_key_ready, 0);
    check("first_beat_latency", o_valid, 1);
  endtask

  task automatic drain(input bit rand_ready, input bit noise, input int stop_round, input int budget);
    logic [47:0] h_sub;
    logic [4:0]  h_round;
    logic        h_last;
    bit          stalled;
    int          cyc;
    beat_t       e;
    stalled = 1'b0;
    cyc     = 0;
    h_sub   = '0;
    h_round = '0;
    h_last  = 1'b0;
    while (sb.size() > 0 && cyc < budget) begin
      if (stop_round != 0 && o_valid && o_round == 5'(stop_round)) break;
      if (stalled) begin
        check("stall_valid", o_valid, 1);
        check("stall_subkey", o_sub, h_sub);
        check("stall_round", o_round, h_round);
        check("stall_last", o_last, h_last);
      end
      if (noise) check("key_ready_run", o_key_ready, 0);
      drv_ready     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      drv_key_valid = noise && !o_key_ready && ($urandom_range(0, 1) == 1);
      drv_key       = {$urandom, $urandom};
      if (!rand_ready) check("stream_valid", o_valid, 1);
      if (o_valid && drv_ready) begin
        e = sb.pop_front();
        check("subkey", o_sub, e.subkey);
        check("subkey_round", o_round, e.round);
        check("subkey_last", o_last, e.last);
      end
      stalled = o_valid && !drv_ready;
      h_sub   = o_sub;
      h_round = o_round;
      h_last  = o_last;
      @(posedge clk); #1;
      cyc++;
    end
    drv_key_valid = 1'b0;
    if (stop_round == 0) begin
      check("all_beats_seen", sb.size(), 0);
      check("valid_after_last", o_valid, 0);
      check("key_ready_after_last", o_key_ready, 1);
    end else begin
      check("reached_stop_round", o_round, stop_round);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_ready", o_key_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_subkey", o_sub, 0);
    check("rst_round", o_round, 0);
    check("rst_last", o_last, 0);
    check("rst_valid_r4", bus4.subkey_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("key_ready_post_rst", o_key_ready, 1);
    check("key_ready_post_rst_r4", bus4.key_ready, 1);

    // Encrypt, decrypt and parity-flipped key, consumer always ready.
    send_key(KEY, 1'b0, 16);
    drain(1'b0, 1'b0, 0, 40);
    send_key(KEY, 1'b1, 16);
    drain(1'b0, 1'b0, 0, 40);
    send_key(KEY ^ PARITY, 1'b0, 16);
    drain(1'b0, 1'b0, 0, 40);

    // Random backpressure with stray key_valid pulses while busy.
    send_key(KEY, 1'b0, 16);
    drain(1'b1, 1'b1, 0, 400);
    send_key(KEY, 1'b1, 16);
    drain(1'b1, 1'b1, 0, 400);

    // Reset in the middle of a sequence, then a clean restart.
    send_key(KEY, 1'b0, 16);
    drain(1'b0, 1'b0, 7, 40);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_subkey", o_sub, 0);
    check("midrst_round", o_round, 0);
    check("midrst_last", o_last, 0);
    check("midrst_key_ready", o_key_ready, 0);
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    check("key_ready_after_midrst", o_key_ready, 1);
    send_key(KEY, 1'b1, 16);
    drain(1'b1, 1'b0, 0, 400);

    // Reduced-round instance.
    sel = 1'b1;
    #1;
    send_key(KEY, 1'b0, 4);
    drain(1'b0, 1'b0, 0, 20);
    send_key(KEY, 1'b1, 4);
    drain(1'b1, 1'b0, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
